// File: rtl/em_pipe_reg_pkg.sv
// em_pipe_reg_pkg: constants shared by the Execute->Memory pipeline register.
//   - Default field widths and the bubble opcode.
//   - A few opcode encodings used by Execute/Memory.
//   - Slot bit-vector width and field offsets. A slot is packed MSB->LSB as
//     {valid, op, valE, valA, dstE, dstM}.
package em_pipe_reg_pkg;

    localparam int OP_W_DEF   = 6;
    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    // Decoded downstream as a no-op.
    localparam logic [5:0] BUBBLE_OP_DEF = 6'b111111;

    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_SUB   = 6'h01;
    localparam logic [5:0] OP_IADDI = 6'h08;
    localparam logic [5:0] OP_LOAD  = 6'h10;
    localparam logic [5:0] OP_STORE = 6'h11;

    function automatic int slot_w(int op_w, int data_w, int reg_w);
        return 1 + op_w + 2 * data_w + 2 * reg_w;
    endfunction

    // Field offsets (LSB position of each field in the slot vector).
    function automatic int off_dstm();
        return 0;
    endfunction

    function automatic int off_dste(int reg_w);
        return reg_w;
    endfunction

    function automatic int off_vala(int reg_w);
        return 2 * reg_w;
    endfunction

    function automatic int off_vale(int data_w, int reg_w);
        return 2 * reg_w + data_w;
    endfunction

    function automatic int off_op(int data_w, int reg_w);
        return 2 * reg_w + 2 * data_w;
    endfunction

    function automatic int off_valid(int op_w, int data_w, int reg_w);
        return 2 * reg_w + 2 * data_w + op_w;
    endfunction

endpackage

// File: rtl/em_pipe_reg_slot.sv
// em_pipe_slot: one register slot of the E->M pipeline.
//   clk           : rising-edge clock
//   reset         : synchronous active-high; loads BUBBLE
//   hold_i        : keep current contents (wins over load_bubble_i)
//   load_bubble_i : load BUBBLE instead of d_i
//   d_i           : next slot contents
//   q_o           : registered slot contents
module em_pipe_slot #(
    parameter int          W      = 8,
    parameter logic [W-1:0] BUBBLE = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         hold_i,
    input  logic         load_bubble_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] slot_q;
    logic [W-1:0] slot_d;

    always_comb begin
        slot_d = slot_q;
        if (hold_i) begin
            slot_d = slot_q;
        end else if (load_bubble_i) begin
            slot_d = BUBBLE;
        end else begin
            slot_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q <= BUBBLE;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign q_o = slot_q;

endmodule

// File: rtl/em_pipe_reg.sv
// em_pipe_reg: parametrised Execute->Memory pipeline register, DEPTH slots
// in series (latency DEPTH cycles), with stall (hold all), bubble (NOP into
// slot 0) and a per-slot valid bit. M_* are driven straight from the last
// slot's flops.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset (-> bubbles)
//   stall, bubble         : hazard-unit controls; stall wins over bubble
//   E_valid, E_op, e_valE, E_valA, E_dstE, E_dstM : Execute-side inputs
//   M_valid, M_op, M_valE, M_valA, M_dstE, M_dstM : Memory-side outputs
//
// Optional macro EM_PIPE_PERF_EN adds saturating 32-bit counters
//   perf_stall_cnt, perf_bubble_cnt, perf_retire_cnt (cleared by reset).
module em_pipe_reg
    import em_pipe_reg_pkg::*;
#(
    parameter int              OP_W      = OP_W_DEF,
    parameter int              DATA_W    = DATA_W_DEF,
    parameter int              REG_W     = REG_W_DEF,
    parameter int              DEPTH     = 1,
    parameter logic [OP_W-1:0] BUBBLE_OP = OP_W'(BUBBLE_OP_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              bubble,
    input  logic              E_valid,
    input  logic [OP_W-1:0]   E_op,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [DATA_W-1:0] E_valA,
    input  logic [REG_W-1:0]  E_dstE,
    input  logic [REG_W-1:0]  E_dstM,
`ifdef EM_PIPE_PERF_EN
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_bubble_cnt,
    output logic [31:0]       perf_retire_cnt,
`endif
    output logic              M_valid,
    output logic [OP_W-1:0]   M_op,
    output logic [DATA_W-1:0] M_valE,
    output logic [DATA_W-1:0] M_valA,
    output logic [REG_W-1:0]  M_dstE,
    output logic [REG_W-1:0]  M_dstM
);

    localparam int SW      = slot_w(OP_W, DATA_W, REG_W);
    localparam int O_DSTM  = off_dstm();
    localparam int O_DSTE  = off_dste(REG_W);
    localparam int O_VALA  = off_vala(REG_W);
    localparam int O_VALE  = off_vale(DATA_W, REG_W);
    localparam int O_OP    = off_op(DATA_W, REG_W);
    localparam int O_VALID = off_valid(OP_W, DATA_W, REG_W);

    // Bubble: invalid, no-op opcode, every data/register field zero so that
    // register 0 is the only possible (ignored) write target.
    localparam logic [SW-1:0] BUBBLE_SLOT = {1'b0, BUBBLE_OP, {(SW-1-OP_W){1'b0}}};

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_depth_chk
            $error("em_pipe_reg: DEPTH must be in 1..4");
        end
    endgenerate

    logic [SW-1:0]             in_slot;
    logic                      in_kill;
    logic [DEPTH-1:0][SW-1:0]  slot_q;

    assign in_slot = {E_valid, E_op, e_valE, E_valA, E_dstE, E_dstM};
    // An invalid input is squashed to a bubble so its garbage fields never
    // travel down the pipe.
    assign in_kill = bubble | ~E_valid;

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_slot
            if (k == 0) begin : g_head
                em_pipe_slot #(
                    .W      (SW),
                    .BUBBLE (BUBBLE_SLOT)
                ) u_slot (
                    .clk           (clk),
                    .reset         (reset),
                    .hold_i        (stall),
                    .load_bubble_i (in_kill),
                    .d_i           (in_slot),
                    .q_o           (slot_q[k])
                );
            end else begin : g_body
                em_pipe_slot #(
                    .W      (SW),
                    .BUBBLE (BUBBLE_SLOT)
                ) u_slot (
                    .clk           (clk),
                    .reset         (reset),
                    .hold_i        (stall),
                    .load_bubble_i (1'b0),
                    .d_i           (slot_q[k-1]),
                    .q_o           (slot_q[k])
                );
            end
        end
    endgenerate

    assign M_valid = slot_q[DEPTH-1][O_VALID];
    assign M_op    = slot_q[DEPTH-1][O_OP +: OP_W];
    assign M_valE  = slot_q[DEPTH-1][O_VALE +: DATA_W];
    assign M_valA  = slot_q[DEPTH-1][O_VALA +: DATA_W];
    assign M_dstE  = slot_q[DEPTH-1][O_DSTE +: REG_W];
    assign M_dstM  = slot_q[DEPTH-1][O_DSTM +: REG_W];

`ifdef EM_PIPE_PERF_EN
    // Valid bit of whatever will land in the output slot on this edge.
    logic entering_valid;

    generate
        if (DEPTH == 1) begin : g_ent1
            assign entering_valid = E_valid & ~bubble;
        end else begin : g_entn
            assign entering_valid = slot_q[DEPTH-2][O_VALID];
        end
    endgenerate

    logic [31:0] stall_cnt_q,  stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (bubble && !stall && bubble_cnt_q != 32'hFFFF_FFFF) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
        if (entering_valid && !stall && retire_cnt_q != 32'hFFFF_FFFF) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            retire_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign perf_stall_cnt  = stall_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
    assign perf_retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_em_pipe_reg.sv
// Bench for em_pipe_reg: three instances (DEPTH 1, 2, 4) share one input
// stream; each is checked against an array-of-slots reference model after
// every edge, plus directed constant checks.
module tb_em_pipe_reg;
    import em_pipe_reg_pkg::*;

    localparam int ND = 3;

    typedef struct packed {
        logic        v;
        logic [5:0]  op;
        logic [31:0] valE;
        logic [31:0] valA;
        logic [4:0]  dstE;
        logic [4:0]  dstM;
    } slot_t;

    localparam slot_t BUB = '{v: 1'b0, op: 6'h3F, valE: 32'd0, valA: 32'd0, dstE: 5'd0, dstM: 5'd0};

    function automatic int dep(int g);
        return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    endfunction

    logic        clk = 1'b0;
    logic        reset, stall, bubble, E_valid;
    logic [5:0]  E_op;
    logic [31:0] e_valE, E_valA;
    logic [4:0]  E_dstE, E_dstM;

    logic        mv   [ND];
    logic [5:0]  mop  [ND];
    logic [31:0] mvE  [ND];
    logic [31:0] mvA  [ND];
    logic [4:0]  mdE  [ND];
    logic [4:0]  mdM  [ND];
    logic [31:0] ps   [ND];
    logic [31:0] pb   [ND];
    logic [31:0] pr   [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        em_pipe_reg #(.DEPTH(dep(g))) u_dut (
            .clk             (clk),
            .reset           (reset),
            .stall           (stall),
            .bubble          (bubble),
            .E_valid         (E_valid),
            .E_op            (E_op),
            .e_valE          (e_valE),
            .E_valA          (E_valA),
            .E_dstE          (E_dstE),
            .E_dstM          (E_dstM),
`ifdef EM_PIPE_PERF_EN
            .perf_stall_cnt  (ps[g]),
            .perf_bubble_cnt (pb[g]),
            .perf_retire_cnt (pr[g]),
`endif
            .M_valid         (mv[g]),
            .M_op            (mop[g]),
            .M_valE          (mvE[g]),
            .M_valA          (mvA[g]),
            .M_dstE          (mdE[g]),
            .M_dstM          (mdM[g])
        );
`ifndef EM_PIPE_PERF_EN
        assign ps[g] = '0;
        assign pb[g] = '0;
        assign pr[g] = '0;
`endif
    end

    // Reference model: slot contents per instance and expected perf counts.
    slot_t       pm [ND][4];
    int unsigned es, eb;
    int unsigned er [ND];

    int nvec = 0;
    int nerr = 0;

    task automatic cmp(input string tag, input logic [80:0] obs, input logic [80:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic slot_t obs_slot(int g);
        obs_slot = '{v: mv[g], op: mop[g], valE: mvE[g], valA: mvA[g], dstE: mdE[g], dstM: mdM[g]};
    endfunction

    task automatic model_edge();
        slot_t nin;
        slot_t ent;
        nin = (E_valid && !bubble)
            ? '{v: 1'b1, op: E_op, valE: e_valE, valA: E_valA, dstE: E_dstE, dstM: E_dstM}
            : BUB;
        if (reset) begin
            es = 0;
            eb = 0;
        end else if (stall) begin
            es++;
        end else if (bubble) begin
            eb++;
        end
        for (int g = 0; g < ND; g++) begin
            if (reset) begin
                for (int k = 0; k < 4; k++) pm[g][k] = BUB;
                er[g] = 0;
            end else if (!stall) begin
                ent = (dep(g) == 1) ? nin : pm[g][dep(g)-2];
                if (ent.v) er[g]++;
                for (int k = 3; k > 0; k--) pm[g][k] = pm[g][k-1];
                pm[g][0] = nin;
            end
        end
    endtask

    // One rising edge: update model with the inputs seen at the edge, then
    // check every instance 1 time unit later.
    task automatic edge_chk();
        @(posedge clk);
        model_edge();
        #1;
        for (int g = 0; g < ND; g++) begin
            cmp($sformatf("model_d%0d", dep(g)), 81'(obs_slot(g)), 81'(pm[g][dep(g)-1]));
`ifdef EM_PIPE_PERF_EN
            cmp($sformatf("perf_stall_d%0d", dep(g)), 81'(ps[g]), 81'(es));
            cmp($sformatf("perf_bubble_d%0d", dep(g)), 81'(pb[g]), 81'(eb));
            cmp($sformatf("perf_retire_d%0d", dep(g)), 81'(pr[g]), 81'(er[g]));
`endif
        end
    endtask

    task automatic drv(input logic r, input logic s, input logic b, input logic v,
                       input logic [5:0] op, input logic [31:0] vE, input logic [31:0] vA,
                       input logic [4:0] dE, input logic [4:0] dM);
        reset = r; stall = s; bubble = b; E_valid = v; E_op = op;
        e_valE = vE; E_valA = vA; E_dstE = dE; E_dstM = dM;
    endtask

    initial begin
        int seen;
        for (int g = 0; g < ND; g++) begin
            er[g] = 0;
            for (int k = 0; k < 4; k++) pm[g][k] = BUB;
        end
        es = 0; eb = 0;

        // Reset held two edges with a live instruction on the inputs.
        drv(1, 0, 0, 1, OP_IADDI, 32'd5, 32'd0, 5'd1, 5'd0);
        edge_chk();
        edge_chk();
        cmp("rst_valid", 81'(mv[0]), 81'(0));
        cmp("rst_op", 81'(mop[0]), 81'(6'b111111));
        cmp("rst_valE", 81'(mvE[0]), 81'(0));
        cmp("rst_dstE", 81'(mdE[0]), 81'(0));
        cmp("rst_valid_d4", 81'(mv[2]), 81'(0));

        // Back-to-back stream, DEPTH=1 shows each input one edge later.
        for (int i = 1; i <= 3; i++) begin
            drv(0, 0, 0, 1, OP_ADD, 32'(i), 32'(i), 5'(i), 5'(i));
            edge_chk();
            cmp("stream_valid", 81'(mv[0]), 81'(1));
            cmp("stream_valE", 81'(mvE[0]), 81'(i));
            cmp("stream_dstM", 81'(mdM[0]), 81'(i));
        end

        // Stall on DEPTH=2: capture 0x10, freeze three edges, then release.
        drv(0, 0, 0, 1, OP_STORE, 32'h10, 32'h20, 5'd3, 5'd0);
        edge_chk();
        for (int i = 0; i < 3; i++) begin
            drv(0, 1, 0, 1, OP_ADD, 32'hFF, 32'hFF, 5'd7, 5'd7);
            edge_chk();
            cmp("stall_frozen_d2", 81'(mvE[1]), 81'(3));
        end
        drv(0, 0, 0, 1, OP_ADD, 32'h30, 32'h31, 5'd4, 5'd0);
        edge_chk();
        cmp("stall_release_valE_d2", 81'(mvE[1]), 81'(32'h10));
        cmp("stall_release_valA_d2", 81'(mvA[1]), 81'(32'h20));

        // Bubble replaces value 8 on DEPTH=1.
        drv(0, 0, 0, 1, OP_ADD, 32'd7, 32'd7, 5'd2, 5'd2);
        edge_chk();
        cmp("bub_pre_valE", 81'(mvE[0]), 81'(7));
        drv(0, 0, 1, 1, OP_ADD, 32'd8, 32'd8, 5'd2, 5'd2);
        edge_chk();
        cmp("bub_valid", 81'(mv[0]), 81'(0));
        cmp("bub_dstE", 81'(mdE[0]), 81'(0));
        cmp("bub_dstM", 81'(mdM[0]), 81'(0));
        drv(0, 0, 0, 1, OP_ADD, 32'd9, 32'd9, 5'd2, 5'd2);
        edge_chk();
        cmp("bub_post_valE", 81'(mvE[0]), 81'(9));

        // Invalid input with garbage fields is squashed.
        drv(0, 0, 0, 0, OP_LOAD, 32'hDEAD, 32'hBEEF, 5'd9, 5'd9);
        edge_chk();
        cmp("inval_op", 81'(mop[0]), 81'(6'h3F));
        cmp("inval_valE", 81'(mvE[0]), 81'(0));

        // Stall+bubble: stall wins. Then reset+stall: reset wins.
        drv(0, 0, 0, 1, OP_ADD, 32'd11, 32'd11, 5'd1, 5'd1);
        edge_chk();
        drv(0, 1, 1, 1, OP_ADD, 32'h55, 32'h55, 5'd1, 5'd1);
        edge_chk();
        cmp("stallbub_valid", 81'(mv[0]), 81'(1));
        cmp("stallbub_valE", 81'(mvE[0]), 81'(11));
        drv(1, 1, 0, 1, OP_ADD, 32'h66, 32'h66, 5'd1, 5'd1);
        edge_chk();
        cmp("rststall_valid", 81'(mv[0]), 81'(0));
        cmp("rststall_op", 81'(mop[0]), 81'(6'h3F));
        cmp("rststall_valid_d4", 81'(mv[2]), 81'(0));

        // Ten edges, stalls at 2,5,8 and bubbles at 3,7.
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            drv(0, (i == 2 || i == 5 || i == 8), (i == 3 || i == 7), 1, OP_ADD,
                32'(100 + i), 32'(i), 5'(i), 5'd0);
            edge_chk();
            if (!(i == 2 || i == 5 || i == 8) && mv[0]) seen++;
        end
`ifdef EM_PIPE_PERF_EN
        cmp("perf10_stall", 81'(ps[0]), 81'(3));
        cmp("perf10_bubble", 81'(pb[0]), 81'(2));
        cmp("perf10_retire", 81'(pr[0]), 81'(seen));
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drv(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 6) == 0), ($urandom_range(0, 4) != 0),
                6'($urandom), $urandom, $urandom, 5'($urandom), 5'($urandom));
            edge_chk();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
